// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// OAM DMA engine placed between the CPU memory port and the system bus.
// A CPU write to DMA_REG_ADDR latches the source page and copies DMA_LEN
// bytes from {src,8'h00} upwards into DEST_BASE upwards. One byte moves per
// M-cycle. During the copy the CPU is cut off from the bus. When no copy is
// running, the block is a transparent passthrough.
//
// Ports
//   clk         system clock, shared with the CPU
//   reset       asynchronous reset, active low
//   t_cycle     T-cycle phase 0..3; an M-cycle ends on the edge where it is 3
//   cpu_addr    CPU bus address
//   cpu_enable  CPU bus access enable
//   cpu_write   CPU bus write enable
//   cpu_wdata   CPU bus write data
//   cpu_rdata   read data returned to the CPU
//   bus_addr    downstream address
//   bus_enable  downstream access enable
//   bus_write   downstream write enable
//   bus_wdata   downstream write data
//   bus_rdata   downstream read data
//   dma_active  high while a copy is pending or running
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DEST_BASE    = 16'hFE00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

    state_t      state;
    logic [7:0]  src_reg;
    logic [7:0]  index;
    logic [7:0]  latch;

    logic        reg_hit;
    logic        m_end;

    assign reg_hit    = cpu_enable && (cpu_addr == DMA_REG_ADDR);
    assign m_end      = (t_cycle == 2'd3);
    assign dma_active = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            src_reg <= 8'hFF;
            index   <= 8'd0;
            latch   <= 8'd0;
        end else begin
            // Source byte is sampled at the end of the read half of the M-cycle.
            if (state == XFER && t_cycle == 2'd1) begin
                latch <= bus_rdata;
            end

            // A register write wins over the normal sequencing, so writing
            // mid-transfer simply restarts from the new source page.
            if (reg_hit && cpu_write && m_end) begin
                src_reg <= cpu_wdata;
                index   <= 8'd0;
                state   <= START;
            end else if (m_end) begin
                case (state)
                    START: state <= XFER;
                    XFER: begin
                        if (index == LAST_INDEX) begin
                            state <= IDLE;
                            index <= 8'd0;
                        end else begin
                            index <= index + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus_addr   = cpu_addr;
        bus_enable = cpu_enable;
        bus_write  = cpu_write;
        bus_wdata  = cpu_wdata;
        cpu_rdata  = bus_rdata;

        case (state)
            IDLE: begin
                if (reg_hit) begin
                    bus_enable = 1'b0;
                    bus_write  = 1'b0;
                end
            end
            START: begin
                bus_addr   = 16'h0000;
                bus_enable = 1'b0;
                bus_write  = 1'b0;
                bus_wdata  = 8'h00;
                cpu_rdata  = 8'hFF;
            end
            XFER: begin
                // The DMA owns the bus here; a CPU access to the register
                // itself is served locally and never reaches the bus.
                bus_enable = 1'b1;
                cpu_rdata  = 8'hFF;
                if (t_cycle[1] == 1'b0) begin
                    bus_addr  = {src_reg, index};
                    bus_write = 1'b0;
                    bus_wdata = 8'h00;
                end else begin
                    bus_addr  = DEST_BASE + {8'h00, index};
                    bus_write = 1'b1;
                    bus_wdata = latch;
                end
            end
            default: begin
                bus_enable = 1'b0;
                bus_write  = 1'b0;
            end
        endcase

        if (reg_hit) begin
            cpu_rdata = src_reg;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    bit   [1:0]  tc = 2'd0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_enable = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        dma_active;

    int checks = 0;
    int errors = 0;

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .t_cycle    (tc),
        .cpu_addr   (cpu_addr),
        .cpu_enable (cpu_enable),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .bus_addr   (bus_addr),
        .bus_enable (bus_enable),
        .bus_write  (bus_write),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tc <= tc + 2'd1;

    // Memory model on the downstream bus
    bit [7:0] mem [0:65535];
    int       wr_count = 0;
    assign bus_rdata = mem[bus_addr];

    always @(posedge clk) begin
        if (bus_enable && bus_write) mem[bus_addr] <= bus_wdata;
        if (bus_enable && bus_write && tc == 2'd3 &&
            bus_addr >= 16'hFE00 && bus_addr <= 16'hFE9F)
            wr_count <= wr_count + 1;
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        mem[a] <= v;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a copy is m_k M-cycles old (0 = setup cycle,
    // k>=1 moves byte k-1); it lasts 161 M-cycles after the trigger.
    bit         m_busy;
    int         m_k;
    logic [7:0] m_src;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_src  <= 8'hFF;
        end else if (tc == 2'd3) begin
            if (cpu_enable && cpu_write && cpu_addr == 16'hFF46) begin
                m_src  <= cpu_wdata;
                m_busy <= 1'b1;
                m_k    <= 0;
            end else if (m_busy) begin
                if (m_k == 160) m_busy <= 1'b0;
                else            m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic       hit;
        logic       rd;
        logic [7:0] i8;
        hit = cpu_enable && cpu_addr == 16'hFF46;
        rd  = cpu_enable && !cpu_write;
        chk("dma_active", int'(dma_active), int'(m_busy));
        if (!m_busy) begin
            if (hit) begin
                chk("reg_bus_en", int'(bus_enable), 0);
            end else begin
                chk("pass_addr", int'(bus_addr), int'(cpu_addr));
                chk("pass_en", int'(bus_enable), int'(cpu_enable));
                chk("pass_wr", int'(bus_write), int'(cpu_write));
                chk("pass_wdata", int'(bus_wdata), int'(cpu_wdata));
            end
            if (rd) chk("idle_rdata", int'(cpu_rdata), hit ? int'(m_src) : int'(mem[cpu_addr]));
        end else begin
            if (m_k == 0) begin
                chk("start_en", int'(bus_enable), 0);
            end else begin
                i8 = 8'(m_k - 1);
                chk("xfer_en", int'(bus_enable), 1);
                if (tc < 2) begin
                    chk("rd_addr", int'(bus_addr), int'({m_src, i8}));
                    chk("rd_wr", int'(bus_write), 0);
                end else begin
                    chk("wr_addr", int'(bus_addr), 32'hFE00 + int'(i8));
                    chk("wr_wr", int'(bus_write), 1);
                    chk("wr_data", int'(bus_wdata), int'(mem[{m_src, i8}]));
                end
            end
            if (rd) chk("busy_rdata", int'(cpu_rdata), hit ? int'(m_src) : 32'hFF);
        end
    end

    task automatic drive_m(input logic en, input logic wr,
                           input logic [15:0] a, input logic [7:0] d);
        while (tc != 2'd0) begin
            @(posedge clk); #1;
        end
        cpu_enable = en;
        cpu_write  = wr;
        cpu_addr   = a;
        cpu_wdata  = d;
    endtask

    task automatic end_m;
        do begin
            @(posedge clk); #1;
        end while (tc != 2'd0);
        cpu_enable = 1'b0;
        cpu_write  = 1'b0;
    endtask

    task automatic m_cycle(input logic en, input logic wr,
                           input logic [15:0] a, input logic [7:0] d);
        drive_m(en, wr, a, d);
        end_m();
    endtask

    task automatic rand_idle_op;
        int k;
        k = $urandom_range(0, 2);
        if (k == 0) m_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        else if (k == 1) m_cycle(1'b1, 1'b0, 16'($urandom), 8'h00);
        else m_cycle(1'b1, 1'b1, 16'hC000 + 16'($urandom_range(1, 255)), 8'($urandom));
    endtask

    task automatic rand_busy_op;
        int         k;
        logic [15:0] a;
        k = $urandom_range(0, 2);
        a = 16'($urandom);
        if (a == 16'hFF46) a = 16'hC000;
        if (k == 0) m_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        else if (k == 1) m_cycle(1'b1, 1'b0, a, 8'h00);
        else m_cycle(1'b1, 1'b1, a, 8'($urandom));
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (dma_active && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", n, 0);
    endtask

    task automatic fill_oam(input logic [7:0] v);
        for (int i = 0; i < 160; i++) poke(16'hFE00 + 16'(i), v);
    endtask

    bit [7:0] dexp [160];
    bit [7:0] zexp [160];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int base;
        for (int i = 0; i < 160; i++) begin
            poke(16'hC100 + 16'(i), 8'(i) ^ 8'hA5);
            dexp[i] = 8'($urandom);
            zexp[i] = 8'($urandom);
            poke(16'hD000 + 16'(i), dexp[i]);
            poke(16'h0000 + 16'(i), zexp[i]);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", int'(dma_active), 0);
        reset = 1'b1;
        drive_m(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        chk("rst_src", int'(cpu_rdata), 32'hFF);
        end_m();

        // Idle passthrough
        poke(16'hC000, 8'h5A);
        drive_m(1'b1, 1'b0, 16'hC000, 8'h00);
        @(negedge clk);
        chk("idle_rd_addr", int'(bus_addr), 32'hC000);
        chk("idle_rd_data", int'(cpu_rdata), 32'h5A);
        end_m();
        drive_m(1'b1, 1'b1, 16'hC001, 8'h33);
        @(negedge clk);
        chk("idle_wr", int'(bus_write), 1);
        chk("idle_wdata", int'(bus_wdata), 32'h33);
        end_m();
        chk("idle_mem", int'(mem[16'hC001]), 32'h33);
        repeat (20) rand_idle_op();

        // Full copy with blocking checks
        fill_oam(8'h77);
        poke(16'hC000, 8'h42);
        base = wr_count;
        m_cycle(1'b1, 1'b1, 16'hFF46, 8'hC1);
        fork
            begin
                wait_idle(n);
                chk("active_clks", n, 644);
            end
            begin
                repeat (2) m_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
                drive_m(1'b1, 1'b0, 16'h8000, 8'h00);
                @(negedge clk);
                chk("blk_rdata", int'(cpu_rdata), 32'hFF);
                end_m();
                m_cycle(1'b1, 1'b1, 16'hC000, 8'h99);
                drive_m(1'b1, 1'b0, 16'hFF46, 8'h00);
                @(negedge clk);
                chk("blk_reg_rd", int'(cpu_rdata), 32'hC1);
                end_m();
                repeat (60) rand_busy_op();
            end
        join
        chk("blk_mem", int'(mem[16'hC000]), 32'h42);
        chk("copy_writes", wr_count - base, 160);
        for (int i = 0; i < 160; i++)
            chk("copy_oam", int'(mem[16'hFE00 + 16'(i)]), int'(8'(i) ^ 8'hA5));
        $display("copy C1 done");

        // Restart mid-transfer
        repeat (5) rand_idle_op();
        fill_oam(8'h77);
        base = wr_count;
        m_cycle(1'b1, 1'b1, 16'hFF46, 8'hC1);
        repeat (51) m_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("pre_restart_writes", wr_count - base, 50);
        m_cycle(1'b1, 1'b1, 16'hFF46, 8'hD0);
        base = wr_count;
        drive_m(1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("restart_start_en", int'(bus_enable), 0);
        end_m();
        drive_m(1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("restart_first_addr", int'(bus_addr), 32'hD000);
        end_m();
        wait_idle(n);
        chk("restart_writes", wr_count - base, 160);
        for (int i = 0; i < 160; i++)
            chk("restart_oam", int'(mem[16'hFE00 + 16'(i)]), int'(dexp[i]));
        $display("restart D0 done");

        // Back-to-back trigger with page 0x00
        base = wr_count;
        m_cycle(1'b1, 1'b1, 16'hFF46, 8'h00);
        wait_idle(n);
        chk("b2b_writes", wr_count - base, 160);
        for (int i = 0; i < 160; i++)
            chk("b2b_oam", int'(mem[16'hFE00 + 16'(i)]), int'(zexp[i]));
        drive_m(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        chk("b2b_src", int'(cpu_rdata), 32'h00);
        end_m();
        $display("back-to-back 00 done");

        // Asynchronous reset during byte 10
        fill_oam(8'h77);
        m_cycle(1'b1, 1'b1, 16'hFF46, 8'hC1);
        repeat (11) m_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("arst_bus_write", int'(bus_write), 0);
        chk("arst_active", int'(dma_active), 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("arst_fe0a", int'(mem[16'hFE0A]), 32'h77);
        chk("arst_fe09", int'(mem[16'hFE09]), int'(8'h09 ^ 8'hA5));
        drive_m(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        chk("arst_src", int'(cpu_rdata), 32'hFF);
        end_m();
        $display("async reset done");

        repeat (10) rand_idle_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sits on the system bus directly downstream of the CPU, between the CPU memory port and the memory/peripheral bus.
- Owns register 0xFF46. Writing it copies 160 bytes from {src,8'h00}..{src,8'h9F} to 0xFE00..0xFE9F, one byte per M-cycle.
- While a copy runs, CPU bus accesses are blocked. When idle, the block is a transparent passthrough.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the source/trigger register.
- DMA_LEN, 160, bytes per transfer.
- DEST_BASE, 16'hFE00, destination (OAM) base address.

Ports:
- clk  input  1  system clock (4 MHz), shared with cpu.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- t_cycle  input  2  T-cycle phase 0..3 shared with cpu; an M-cycle ends on the edge where t_cycle==3.
- cpu_addr  input  16  CPU bus address.
- cpu_enable  input  1  CPU access enable.
- cpu_write  input  1  CPU write enable.
- cpu_wdata  input  8  CPU write data.
- cpu_rdata  output  8  read data returned to CPU.
- bus_addr  output  16  downstream address.
- bus_enable  output  1  downstream access enable.
- bus_write  output  1  downstream write enable.
- bus_wdata  output  8  downstream write data.
- bus_rdata  input  8  downstream read data.
- dma_active  output  1  high while in START or XFER.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, src_reg=8'hFF, index=0, latch=0.
  - dma_active=0.
  - Bus outputs follow the IDLE passthrough rules immediately.
- Register access. CPU access with cpu_addr==DMA_REG_ADDR is handled locally in every state:
  - bus_enable=0 for that access.
  - Reads return src_reg.
  - A write commits on the t_cycle==3 edge: src_reg<=cpu_wdata, index<=0, state<=START. This applies from any state, so a write mid-transfer restarts the transfer.
- IDLE:
  - bus_addr/enable/write/wdata = cpu_addr/cpu_enable/cpu_write/cpu_wdata.
  - cpu_rdata=bus_rdata, combinational.
- START:
  - Lasts exactly one M-cycle with no bus activity from DMA; bus_enable=0.
  - Goes to XFER at the next t_cycle==3 edge.
- XFER, one byte per M-cycle:
  - t_cycle 0,1: bus_addr={src_reg,index}, bus_enable=1, bus_write=0. bus_rdata is captured into latch on the edge where t_cycle==1.
  - t_cycle 2,3: bus_addr=DEST_BASE+index, bus_enable=1, bus_write=1, bus_wdata=latch.
  - On the t_cycle==3 edge: if index==DMA_LEN-1, state<=IDLE and index<=0; else index<=index+1.
  - index is 8 bits; the maximum value is 159, so the counter never wraps.
- CPU during START/XFER:
  - Any access other than DMA_REG_ADDR is not forwarded.
  - Reads return 8'hFF; writes are dropped.
  - HRAM is not exempt.
- src_reg is used as-is for any value 0x00..0xFF; there is no echo remapping.
- dma_active is combinational from state.
- Total duration from the trigger-write M-cycle end to return to IDLE: 161 M-cycles (644 clk).
- If reset is asserted mid-transfer, the transfer aborts immediately with no further bus writes.

Test Plan:
- Idle passthrough: CPU reads 0xC000 while the bus model returns 0x5A -> bus_addr=0xC000, cpu_rdata=0x5A. CPU writes 0x33 to 0xC001 -> bus_write=1, bus_wdata=0x33.
- Full copy: preload 0xC100..0xC19F with i^0xA5, CPU writes 0xC1 to 0xFF46:
  - dma_active rises after that M-cycle and stays high for exactly 644 clk.
  - OAM 0xFE00+i == i^0xA5 for all 160 bytes, with exactly 160 bus writes.
- Blocking: during XFER, CPU reads 0x8000 -> cpu_rdata=0xFF and no CPU-originated bus access. CPU writes 0xC000 -> memory unchanged. CPU reads 0xFF46 -> 0xC1.
- Restart: after 50 bytes of a 0xC1 copy, CPU writes 0xD0 to 0xFF46 -> one START M-cycle, then the copy resumes from 0xD000 to 0xFE00. FE00..FE31 are overwritten, with 160 further writes.
- Async reset: pull reset low at t_cycle==2 during byte 10 -> bus_write drops the same cycle, dma_active=0, FF46 reads 0xFF after release, FE0A is not written.
- Back-to-back: after one copy completes, immediately trigger 0x00 -> copies 0x0000..0x009F, and FF46 reads 0x00.
